muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Iterative multi-cycle RV32M multiply/divide execute unit, parametrised in width. It sits beside the single-cycle ALU in the execute stage. It is selected when the decoder sees opcode OP with funct7 = 0000001. It accepts one operation per valid/ready handshake, computes over ~BitWidth cycles, and holds the result until the consumer accepts it.

Parameters:
BitWidth, 32, operand/result width; must be >= 4 and even.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  unit can accept a request; high only in IDLE.
a  input  BitWidth  rs1 operand.
b  input  BitWidth  rs2 operand.
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
out_valid  output  1  result valid; registered.
out_ready  input  1  consumer accepts the result.
y  output  BitWidth  result; registered.
busy  output  1  high in every state except IDLE.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - CALC: one iteration per cycle.
  - FIX: sign correction.
  - DONE: out_valid=1.
- Reset: every output is 0 except in_ready=1. Reset overrides everything, including mid-CALC/FIX/DONE; the pending result is discarded.
- Accept: IDLE and in_valid. Latch funct3, |a|, |b|, and the result sign.
  - Operand signedness: a is signed for MULH, MULHSU, DIV, REM. b is signed for MULH, DIV, REM.
  - Result sign: a_neg^b_neg for MUL*/DIV. a_neg for REM.
  - Load the iteration counter with BitWidth (width $clog2(BitWidth+1)).
- Special cases are decided at accept, skip CALC/FIX, and go straight to DONE, so out_valid is high after 1 edge:
  - DIV/DIVU with b==0: y = all ones.
  - REM/REMU with b==0: y = a.
  - DIV with a==-2^(W-1) and b==-1: y = a.
  - REM with a==-2^(W-1) and b==-1: y = 0.
- Multiply, CALC: shift-add over unsigned magnitudes into a 2*BitWidth accumulator, one multiplier bit per cycle, LSB first.
- Divide, CALC: restoring division over magnitudes, one quotient bit per cycle, MSB first. The partial remainder is BitWidth+1 bits wide.
- Counter decrements each CALC cycle. CALC→FIX when the counter reaches 1 on that edge, i.e. exactly BitWidth CALC cycles.
- FIX, one cycle:
  - If the result sign is set, negate in two's complement. Multiply negates the full 2W product; divide negates the quotient (DIV) or the remainder (REM).
  - Select the output: MUL = low W bits; MULH/MULHSU/MULHU = high W bits; DIV* = quotient; REM* = remainder.
  - Register y, set out_valid, go to DONE.
- Normal latency: out_valid is first high BitWidth+2 edges after the accept edge (34 for W=32).
- DONE:
  - y and out_valid are held stable while out_ready=0 (unbounded backpressure).
  - On out_ready=1: out_valid→0, state→IDLE. y keeps its value; consumers use it only while out_valid is high.
- No same-cycle accept in DONE: in_ready=0 until IDLE. Maximum throughput is one op per BitWidth+3 cycles.
- in_valid, a, b, funct3 changes while busy: ignored.
- Operand magnitudes: |−2^(W-1)| = 2^(W-1) is represented unsigned in W bits with no overflow.
- Unsigned operands (MULHU, DIVU, REMU, and b in MULHSU) are never negated.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (−3), out_ready=1 → y=0xFFFFFFEB; out_valid rises exactly 34 edges after accept; in_ready low throughout.
- High products:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU a=0xFFFFFFFF (−1), b=0xFFFFFFFF → 0xFFFFFFFF.
- Division:
  - DIV −7/2 → 0xFFFFFFFD; REM −7%2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC; REMU → 1.
- Special cases, each with out_valid after 1 edge:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Backpressure: complete MUL 3×4 while holding out_ready=0 for 5 cycles → y=12 and out_valid stay stable, in_ready=0. Raise out_ready → one edge later out_valid=0, in_ready=1. Next op accepted the following cycle.
- Reset in middle of CALC (edge 10 of DIV 100/7) → state IDLE, out_valid=0, y=0, in_ready=1. A fresh DIVU 100/7 then returns 14 with full latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one result bit per cycle, held until accepted.
module muldiv_unit #(
  parameter int BitWidth = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BitWidth-1:0] a,
  input  logic [BitWidth-1:0] b,
  input  logic [2:0]          funct3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BitWidth-1:0] y,
  output logic                busy
);
  localparam int W  = BitWidth;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0]     f3_q, f3_d;
  logic           sign_q, sign_d, ov_q, ov_d;
  logic [W-1:0]   am_q, am_d, bm_q, bm_d, y_q, y_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W:0]     rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf, special, res_sign, take;
  logic [W-1:0]   a_mag, b_mag, spec_y, y_fix;
  logic [W:0]     mul_sum, rem_sh;
  logic [W+1:0]   diff;
  logic [2*W-1:0] mag, fixd;
  assign a_sgn    = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
  assign b_sgn    = funct3 inside {3'b001, 3'b100, 3'b110};
  assign a_neg    = a_sgn & a[W-1];
  assign b_neg    = b_sgn & b[W-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign b_zero   = b == '0;
  assign ovf      = (funct3 == 3'b100 || funct3 == 3'b110) && a == {1'b1, {(W-1){1'b0}}} && b == '1;
  assign special  = funct3[2] & (b_zero | ovf);
  assign spec_y   = funct3[1] ? (b_zero ? a : '0) : (b_zero ? '1 : a);
  assign res_sign = (funct3[2] & funct3[1]) ? a_neg : a_neg ^ b_neg;
  // Multiply: accumulate into the high half, multiplier bits shift out of the low half.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, am_q} : '0);
  // Divide: dividend shifts out of acc MSB-first while quotient bits shift in at the LSB.
  assign rem_sh   = {rem_q[W-1:0], acc_q[W-1]};
  assign diff     = {1'b0, rem_sh} - {2'b0, bm_q};
  assign take     = ~diff[W+1];
  assign mag      = f3_q[2] ? {{W{1'b0}}, f3_q[1] ? rem_q[W-1:0] : acc_q[W-1:0]} : acc_q;
  assign fixd     = sign_q ? -mag : mag;
  assign y_fix    = (f3_q[2] || f3_q[1:0] == 2'b00) ? fixd[W-1:0] : fixd[2*W-1:W];
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    sign_d  = sign_q;
    am_d    = am_q;
    bm_d    = bm_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: if (in_valid) begin
        f3_d    = funct3;
        sign_d  = res_sign;
        am_d    = a_mag;
        bm_d    = b_mag;
        acc_d   = {{W{1'b0}}, funct3[2] ? a_mag : b_mag};
        rem_d   = '0;
        cnt_d   = CW'(W);
        y_d     = special ? spec_y : y_q;
        ov_d    = special;
        state_d = special ? DONE : CALC;
      end
      CALC: begin
        acc_d   = f3_q[2] ? {acc_q[2*W-1:W], acc_q[W-2:0], take} : {mul_sum, acc_q[W-1:1]};
        rem_d   = f3_q[2] ? (take ? diff[W:0] : rem_sh) : rem_q;
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? FIX : CALC;
      end
      FIX: begin
        y_d     = y_fix;
        ov_d    = 1'b1;
        state_d = DONE;
      end
      default: if (out_ready) begin
        ov_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      f3_q    <= '0;
      sign_q  <= 1'b0;
      am_q    <= '0;
      bm_q    <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      sign_q  <= sign_d;
      am_q    <= am_d;
      bm_q    <= bm_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      ov_q    <= ov_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = ov_q;
  assign y         = y_q;
endmodule
